fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit
// ----------
// Instruction fetch stage in front of a combinational 1024-word instruction ROM.
// Each cycle in RUN it does one of the following, in this priority order:
//   1. Halt: enter HALT.
//   2. Redirect: load a new PC. A bad target enters FAULT instead.
//   3. Stall: hold everything.
//   4. Sequential fetch: latch the ROM word into IR and advance PC by 4.
// HALT and FAULT hold all architectural state and can only be left through reset.
//
// Ports
//   CLK         in   1   clock, rising-edge
//   RST_n       in   1   synchronous reset, active-low
//   Stall       in   1   hold PC/IR this cycle
//   Redirect    in   1   load RedirectPC
//   RedirectPC  in  32   redirect byte address
//   Halt        in   1   halt request
//   RomData     in  32   ROM word at Address
//   Address     out 10   ROM word address (PC[11:2])
//   PC          out 32   current fetch byte address
//   IR          out 32   latched instruction
//   IRPC        out 32   byte address of IR
//   IRValid     out  1   IR holds a valid, non-squashed instruction
//   State       out  2   RUN=00, HALT=01, FAULT=10
//   Halted      out  1   State==HALT
//   Fault       out  1   State==FAULT
//   FetchCount  out 32   valid instructions loaded into IR (wraps)

module fetch_unit (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic        Halt,
    input  logic [31:0] RomData,
    output logic [9:0]  Address,
    output logic [31:0] PC,
    output logic [31:0] IR,
    output logic [31:0] IRPC,
    output logic        IRValid,
    output logic [1:0]  State,
    output logic        Halted,
    output logic        Fault,
    output logic [31:0] FetchCount
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HALT  = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    // Byte address of the last ROM word; sequential fetch cannot advance past it.
    localparam logic [31:0] LAST_PC = 32'h0000_0FFC;

    state_t      state_reg,   state_next;
    logic [31:0] pc_reg,      pc_next;
    logic [31:0] ir_reg,      ir_next;
    logic [31:0] irpc_reg,    irpc_next;
    logic        irvalid_reg, irvalid_next;
    logic [31:0] count_reg,   count_next;

    // A target is legal only if it is word-aligned and inside the 4 KiB ROM window.
    logic redirect_bad;
    assign redirect_bad = (RedirectPC[1:0] != 2'b00) || (RedirectPC[31:12] != 20'd0);

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_reg   <= ST_RUN;
            pc_reg      <= 32'd0;
            ir_reg      <= 32'd0;
            irpc_reg    <= 32'd0;
            irvalid_reg <= 1'b0;
            count_reg   <= 32'd0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            ir_reg      <= ir_next;
            irpc_reg    <= irpc_next;
            irvalid_reg <= irvalid_next;
            count_reg   <= count_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        ir_next      = ir_reg;
        irpc_next    = irpc_reg;
        irvalid_next = irvalid_reg;
        count_next   = count_reg;

        case (state_reg)
            ST_RUN: begin
                if (Halt) begin
                    state_next   = ST_HALT;
                    irvalid_next = 1'b0;
                end else if (Redirect) begin
                    // The word fetched this cycle is wrong-path, so it is squashed
                    // whether or not the target is usable. Stall does not matter here.
                    irvalid_next = 1'b0;
                    if (redirect_bad) begin
                        state_next = ST_FAULT;
                    end else begin
                        pc_next = RedirectPC;
                    end
                end else if (!Stall) begin
                    ir_next      = RomData;
                    irpc_next    = pc_reg;
                    irvalid_next = 1'b1;
                    count_next   = count_reg + 32'd1;
                    // The last word is still delivered, but there is no next word to
                    // fetch, so PC parks there and the unit faults.
                    if (pc_reg == LAST_PC) begin
                        state_next = ST_FAULT;
                    end else begin
                        pc_next = pc_reg + 32'd4;
                    end
                end
            end
            default: begin
                // HALT and FAULT: everything is frozen; only IRValid is cleared.
                irvalid_next = 1'b0;
            end
        endcase
    end

    assign Address    = pc_reg[11:2];
    assign PC         = pc_reg;
    assign IR         = ir_reg;
    assign IRPC       = irpc_reg;
    assign IRValid    = irvalid_reg;
    assign State      = state_reg;
    assign Halted     = (state_reg == ST_HALT);
    assign Fault      = (state_reg == ST_FAULT);
    assign FetchCount = count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. A ROM array models the instruction memory.
// Inputs are driven #1 after the rising edge, and outputs are checked at that same point.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        Halt;
    logic [31:0] RomData;
    logic [9:0]  Address;
    logic [31:0] PC;
    logic [31:0] IR;
    logic [31:0] IRPC;
    logic        IRValid;
    logic [1:0]  State;
    logic        Halted;
    logic        Fault;
    logic [31:0] FetchCount;

    logic [31:0] rom [0:1023];

    integer tests_run = 0;
    integer tests_failed = 0;

    fetch_unit dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .Stall      (Stall),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .Halt       (Halt),
        .RomData    (RomData),
        .Address    (Address),
        .PC         (PC),
        .IR         (IR),
        .IRPC       (IRPC),
        .IRValid    (IRValid),
        .State      (State),
        .Halted     (Halted),
        .Fault      (Fault),
        .FetchCount (FetchCount)
    );

    always #5 CLK = ~CLK;

    assign RomData = rom[Address];

    task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run = tests_run + 1;
        if (observed !== expected) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end else begin
            $display("ok   %s: 0x%08h", tag, observed);
        end
    endtask

    // Advance one rising edge, then settle so the new outputs can be sampled.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic idle_inputs();
        Stall = 1'b0; Redirect = 1'b0; RedirectPC = 32'd0; Halt = 1'b0;
    endtask

    task automatic do_reset();
        RST_n = 1'b0;
        idle_inputs();
        step(1);
        RST_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 32'hA5000000 | i;
        rom[0] = 32'h00100513;
        rom[1] = 32'h01000093;
        rom[2] = 32'h00200593;

        idle_inputs();
        do_reset();
        check_eq("reset_pc", PC, 32'h0);
        check_eq("reset_state", {30'd0, State}, 32'h0);
        check_eq("reset_irvalid", {31'd0, IRValid}, 32'h0);

        // Reset in the middle of a run.
        step(16);
        check_eq("run16_pc", PC, 32'h40);
        check_eq("run16_count", FetchCount, 32'd16);
        RST_n = 1'b0;
        step(1);
        check_eq("midreset_pc", PC, 32'h0);
        check_eq("midreset_addr", {22'd0, Address}, 32'h0);
        check_eq("midreset_irvalid", {31'd0, IRValid}, 32'h0);
        check_eq("midreset_count", FetchCount, 32'h0);
        check_eq("midreset_state", {30'd0, State}, 32'h0);
        // While reset stays low, the outputs keep their reset values.
        step(1);
        check_eq("heldreset_pc", PC, 32'h0);
        check_eq("heldreset_ir", IR, 32'h0);
        RST_n = 1'b1;

        // Sequential fetch.
        step(3);
        check_eq("seq_pc", PC, 32'hC);
        check_eq("seq_ir", IR, 32'h00200593);
        check_eq("seq_irpc", IRPC, 32'h8);
        check_eq("seq_irvalid", {31'd0, IRValid}, 32'h1);
        check_eq("seq_count", FetchCount, 32'd3);

        // Redirect together with Stall: the redirect still takes effect.
        do_reset();
        step(2);
        check_eq("pre_redir_pc", PC, 32'h8);
        Redirect = 1'b1; RedirectPC = 32'h44; Stall = 1'b1;
        step(1);
        idle_inputs();
        check_eq("redir_pc", PC, 32'h44);
        check_eq("redir_addr", {22'd0, Address}, 32'h11);
        check_eq("redir_irvalid", {31'd0, IRValid}, 32'h0);
        check_eq("redir_count", FetchCount, 32'd2);
        check_eq("redir_irpc_hold", IRPC, 32'h4);
        step(1);
        check_eq("post_redir_irpc", IRPC, 32'h44);
        check_eq("post_redir_ir", IR, 32'hA5000011);
        check_eq("post_redir_pc", PC, 32'h48);

        // Stall alone holds everything.
        Stall = 1'b1;
        step(2);
        Stall = 1'b0;
        check_eq("stall_pc", PC, 32'h48);
        check_eq("stall_irpc", IRPC, 32'h44);
        check_eq("stall_irvalid", {31'd0, IRValid}, 32'h1);
        check_eq("stall_count", FetchCount, 32'd3);

        // A misaligned redirect faults.
        Redirect = 1'b1; RedirectPC = 32'h46;
        step(1);
        check_eq("mis_state", {30'd0, State}, 32'h2);
        check_eq("mis_fault", {31'd0, Fault}, 32'h1);
        check_eq("mis_pc", PC, 32'h48);
        check_eq("mis_irvalid", {31'd0, IRValid}, 32'h0);
        RedirectPC = 32'h40;
        step(2);
        Redirect = 1'b0;
        step(1);
        check_eq("fault_hold_pc", PC, 32'h48);
        check_eq("fault_hold_state", {30'd0, State}, 32'h2);
        check_eq("fault_hold_count", FetchCount, 32'd3);

        // An out-of-range redirect target faults.
        do_reset();
        Redirect = 1'b1; RedirectPC = 32'h1000;
        step(1);
        idle_inputs();
        check_eq("oor_state", {30'd0, State}, 32'h2);
        check_eq("oor_pc", PC, 32'h0);

        // Halt takes priority over Redirect.
        do_reset();
        step(1);
        Halt = 1'b1; Redirect = 1'b1; RedirectPC = 32'h80;
        step(1);
        check_eq("halt_state", {30'd0, State}, 32'h1);
        check_eq("halt_halted", {31'd0, Halted}, 32'h1);
        check_eq("halt_fault", {31'd0, Fault}, 32'h0);
        check_eq("halt_pc", PC, 32'h4);
        check_eq("halt_irvalid", {31'd0, IRValid}, 32'h0);
        Halt = 1'b0;
        step(2);
        check_eq("halt_hold_pc", PC, 32'h4);
        check_eq("halt_hold_count", FetchCount, 32'd1);
        RST_n = 1'b0;
        step(1);
        RST_n = 1'b1;
        idle_inputs();
        check_eq("halt_reset_state", {30'd0, State}, 32'h0);
        check_eq("halt_reset_pc", PC, 32'h0);

        // Fetch at the top of the ROM.
        Redirect = 1'b1; RedirectPC = 32'hFF8;
        step(1);
        idle_inputs();
        step(1);
        check_eq("top_pre_pc", PC, 32'hFFC);
        step(1);
        check_eq("top_irpc", IRPC, 32'hFFC);
        check_eq("top_ir", IR, 32'hA50003FF);
        check_eq("top_irvalid", {31'd0, IRValid}, 32'h1);
        check_eq("top_pc", PC, 32'hFFC);
        check_eq("top_state", {30'd0, State}, 32'h2);
        check_eq("top_count", FetchCount, 32'd2);
        step(1);
        check_eq("top_next_irvalid", {31'd0, IRValid}, 32'h0);
        check_eq("top_next_count", FetchCount, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
